// File: rtl/regfile_bypass_sb.sv
// regfile_bypass_sb: integer register file for the ID stage.
//   NREAD combinational read ports, one write-back port with same-cycle
//   write-to-read bypass, hard-wired zero register, optional busy scoreboard.
//   Optional feature macro: REGFILE_SCOREBOARD_EN (scoreboard built when defined;
//   otherwise rbusy_o is 0 and issue_ready_o is 1).
// Ports:
//   clk, rst_n      clock, async active-low reset
//   raddr_i         read addresses, port p at [p*AW +: AW]
//   rdata_o         read data, port p at [p*XLEN +: XLEN]
//   rbusy_o         port p's source has an outstanding writer not bypassed now
//   we_i/waddr_i/wdata_i   write-back port
//   issue_valid_i/issue_rd_i  instruction issue marking its destination busy
//   issue_ready_o   issue_rd_i may be marked busy this cycle
module regfile_bypass_sb #(
  parameter int XLEN  = 32,
  parameter int NREGS = 32,
  parameter int NREAD = 2
) (
  input  logic                           clk,
  input  logic                           rst_n,
  input  logic [NREAD*$clog2(NREGS)-1:0] raddr_i,
  output logic [NREAD*XLEN-1:0]          rdata_o,
  output logic [NREAD-1:0]               rbusy_o,
  input  logic                           we_i,
  input  logic [$clog2(NREGS)-1:0]       waddr_i,
  input  logic [XLEN-1:0]                wdata_i,
  input  logic                           issue_valid_i,
  input  logic [$clog2(NREGS)-1:0]       issue_rd_i,
  output logic                           issue_ready_o
);
  localparam int AW = $clog2(NREGS);

  // Writes to r0 and anything while reset is held are dropped here, so every
  // later use (storage, bypass, busy clear) only needs the address compare.
  logic wr_en;
  assign wr_en = we_i & rst_n & (waddr_i != '0);

  logic [XLEN-1:0] regs_q [1:NREGS-1];

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int r = 1; r < NREGS; r++) regs_q[r] <= '0;
    end else if (wr_en) begin
      for (int r = 1; r < NREGS; r++) begin
        if (waddr_i == AW'(r)) regs_q[r] <= wdata_i;
      end
    end
  end

`ifdef REGFILE_SCOREBOARD_EN
  logic [NREGS-1:1] busy_q, busy_d;
  logic [NREGS-1:0] busy_vec;
  logic             iss_en;

  assign busy_vec = {busy_q, 1'b0};

  assign issue_ready_o = !busy_vec[issue_rd_i]
                       || (wr_en && (waddr_i == issue_rd_i))
                       || (issue_rd_i == '0);

  assign iss_en = issue_valid_i & rst_n & issue_ready_o & (issue_rd_i != '0);

  // Set after clear: a re-issue in the write-back cycle leaves the new producer busy.
  always_comb begin
    busy_d = busy_q;
    for (int r = 1; r < NREGS; r++) begin
      if (wr_en && (waddr_i == AW'(r))) busy_d[r] = 1'b0;
      if (iss_en && (issue_rd_i == AW'(r))) busy_d[r] = 1'b1;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) busy_q <= '0;
    else        busy_q <= busy_d;
  end

  a_issue_protocol: assert property (@(posedge clk) disable iff (!rst_n)
                                     issue_valid_i |-> issue_ready_o);
`else
  logic unused_issue;
  assign unused_issue  = issue_valid_i ^ (^issue_rd_i);
  assign issue_ready_o = 1'b1;
`endif

  for (genvar p = 0; p < NREAD; p++) begin : g_rd
    logic [AW-1:0]   ra;
    logic [XLEN-1:0] rd_val;
    logic            hit;

    assign ra  = raddr_i[p*AW +: AW];
    assign hit = wr_en && (waddr_i == ra);

    always_comb begin
      rd_val = '0;
      for (int r = 1; r < NREGS; r++) begin
        if (ra == AW'(r)) rd_val = regs_q[r];
      end
      if (hit) rd_val = wdata_i;
    end

    assign rdata_o[p*XLEN +: XLEN] = rd_val;

`ifdef REGFILE_SCOREBOARD_EN
    assign rbusy_o[p] = busy_vec[ra] && !hit;
`else
    assign rbusy_o[p] = 1'b0;
`endif
  end

endmodule

// File: tb/tb_regfile_bypass_sb.sv
module tb_regfile_bypass_sb;
`ifdef REGFILE_SCOREBOARD_EN
  localparam bit SB = 1'b1;
`else
  localparam bit SB = 1'b0;
`endif

  logic        clk = 1'b0;
  logic        rst_n;
  logic [9:0]  raddr;
  logic [63:0] rdata;
  logic [1:0]  rbusy;
  logic        we;
  logic [4:0]  waddr;
  logic [31:0] wdata;
  logic        issue_valid;
  logic [4:0]  issue_rd;
  logic        issue_ready;

  int checks = 0;
  int errors = 0;

  // Reference model: architectural register values and outstanding writers.
  logic [31:0] mregs [32];
  bit          mbusy [32];

  regfile_bypass_sb #(.XLEN(32), .NREGS(32), .NREAD(2)) dut (
    .clk(clk), .rst_n(rst_n), .raddr_i(raddr), .rdata_o(rdata), .rbusy_o(rbusy),
    .we_i(we), .waddr_i(waddr), .wdata_i(wdata), .issue_valid_i(issue_valid),
    .issue_rd_i(issue_rd), .issue_ready_o(issue_ready)
  );

  always #5 clk = ~clk;

  function automatic logic [31:0] exp_rd(int ra);
    if (!rst_n || ra == 0) return 32'h0;
    if (we && int'(waddr) == ra) return wdata;
    return mregs[ra];
  endfunction

  function automatic logic exp_rbusy(int ra);
    if (!SB || !rst_n) return 1'b0;
    return mbusy[ra] && !(we && int'(waddr) == ra);
  endfunction

  function automatic logic exp_ready(int rd);
    if (!SB || !rst_n || rd == 0) return 1'b1;
    return !mbusy[rd] || (we && int'(waddr) == rd);
  endfunction

  task automatic model_clear();
    for (int r = 0; r < 32; r++) begin
      mregs[r] = 32'h0;
      mbusy[r] = 1'b0;
    end
  endtask

  // Advance one edge, update model with the inputs that were present at it.
  task automatic step();
    bit rdy;
    @(posedge clk);
    if (rst_n) begin
      rdy = exp_ready(int'(issue_rd));
      if (we && waddr != 0) begin
        mregs[waddr] = wdata;
        mbusy[waddr] = 1'b0;
      end
      if (SB && issue_valid && rdy && issue_rd != 0) mbusy[issue_rd] = 1'b1;
    end
    #1;
  endtask

  task automatic idle_inputs();
    we = 1'b0; waddr = '0; wdata = '0; issue_valid = 1'b0; issue_rd = '0;
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    idle_inputs();
    model_clear();
    #2;
    // Write and issue presented during reset must have no visible effect.
    we = 1'b1; waddr = 5'd5; wdata = 32'hCAFEF00D; issue_valid = 1'b1; issue_rd = 5'd5;
    for (int a = 0; a < 32; a++) begin
      raddr = {5'(31 - a), 5'(a)};
      #1;
      checks++;
      if (rdata !== 64'h0 || rbusy !== 2'b00 || issue_ready !== 1'b1) begin
        errors++;
        $display("FAIL reset_outputs addr=%0d got rdata=%h rbusy=%b ready=%b want 0/00/1",
                 a, rdata, rbusy, issue_ready);
      end
    end
    step();
    step();
    idle_inputs();
    rst_n = 1'b1;
    raddr = {5'd5, 5'd5};
    #1;
    checks++;
    if (rdata !== 64'h0 || rbusy !== 2'b00) begin
      errors++;
      $display("FAIL reset_no_write got rdata=%h rbusy=%b want 0/00", rdata, rbusy);
    end
  endtask

  task automatic test_zero_reg();
    we = 1'b1; waddr = 5'd0; wdata = 32'hDEADBEEF; raddr = {5'd0, 5'd0};
    #1;
    checks++;
    if (rdata !== 64'h0) begin
      errors++;
      $display("FAIL zero_same_cycle got %h want 0", rdata);
    end
    step();
    idle_inputs();
    #1;
    checks++;
    if (rdata !== 64'h0) begin
      errors++;
      $display("FAIL zero_next_cycle got %h want 0", rdata);
    end
  endtask

  task automatic test_bypass();
    we = 1'b1; waddr = 5'd6; wdata = $urandom;
    step();
    we = 1'b1; waddr = 5'd5; wdata = 32'h12345678; raddr = {5'd6, 5'd5};
    #1;
    checks++;
    if (rdata[31:0] !== 32'h12345678) begin
      errors++;
      $display("FAIL bypass_p0 got %h want 12345678", rdata[31:0]);
    end
    checks++;
    if (rdata[63:32] !== mregs[6]) begin
      errors++;
      $display("FAIL bypass_p1_old got %h want %h", rdata[63:32], mregs[6]);
    end
    step();
    idle_inputs();
    #1;
    checks++;
    if (rdata[31:0] !== 32'h12345678) begin
      errors++;
      $display("FAIL storage_p0 got %h want 12345678", rdata[31:0]);
    end
  endtask

  task automatic test_scoreboard();
    issue_valid = 1'b1; issue_rd = 5'd7; raddr = {5'd0, 5'd7};
    #1;
    checks++;
    if (issue_ready !== 1'b1) begin
      errors++;
      $display("FAIL issue7_ready got %b want 1", issue_ready);
    end
    step();
    issue_valid = 1'b0; issue_rd = 5'd7;
    #1;
    checks++;
    if (rbusy[0] !== SB || issue_ready !== !SB) begin
      errors++;
      $display("FAIL busy7 got rbusy=%b ready=%b want %b/%b", rbusy[0], issue_ready, SB, !SB);
    end
    we = 1'b1; waddr = 5'd7; wdata = 32'hA5A5A5A5;
    #1;
    checks++;
    if (rbusy[0] !== 1'b0 || rdata[31:0] !== 32'hA5A5A5A5 || issue_ready !== 1'b1) begin
      errors++;
      $display("FAIL wb7_bypass got rbusy=%b rdata=%h ready=%b want 0/a5a5a5a5/1",
               rbusy[0], rdata[31:0], issue_ready);
    end
    step();
    idle_inputs();
    issue_rd = 5'd7;
    #1;
    checks++;
    if (rbusy[0] !== 1'b0 || issue_ready !== 1'b1) begin
      errors++;
      $display("FAIL busy7_cleared got rbusy=%b ready=%b want 0/1", rbusy[0], issue_ready);
    end
  endtask

  task automatic test_same_cycle_reissue();
    issue_valid = 1'b1; issue_rd = 5'd9;
    step();
    raddr = {5'd9, 5'd9};
    we = 1'b1; waddr = 5'd9; wdata = $urandom; issue_valid = 1'b1; issue_rd = 5'd9;
    #1;
    checks++;
    if (issue_ready !== 1'b1 || rbusy !== 2'b00) begin
      errors++;
      $display("FAIL reissue9_cycle got ready=%b rbusy=%b want 1/00", issue_ready, rbusy);
    end
    step();
    idle_inputs();
    #1;
    checks++;
    if (rbusy !== {SB, SB}) begin
      errors++;
      $display("FAIL reissue9_after got rbusy=%b want %b%b", rbusy, SB, SB);
    end
  endtask

  task automatic test_issue_zero();
    issue_valid = 1'b1; issue_rd = 5'd0; raddr = {5'd0, 5'd0};
    #1;
    checks++;
    if (issue_ready !== 1'b1) begin
      errors++;
      $display("FAIL issue0_ready got %b want 1", issue_ready);
    end
    step();
    idle_inputs();
    #1;
    checks++;
    if (rbusy !== 2'b00 || issue_ready !== 1'b1) begin
      errors++;
      $display("FAIL issue0_after got rbusy=%b ready=%b want 00/1", rbusy, issue_ready);
    end
  endtask

  task automatic test_async_reset();
    issue_valid = 1'b1; issue_rd = 5'd3;
    step();
    idle_inputs();
    raddr = {5'd5, 5'd3};
    #1;
    checks++;
    if (rbusy[0] !== SB) begin
      errors++;
      $display("FAIL busy3_set got %b want %b", rbusy[0], SB);
    end
    #1;
    rst_n = 1'b0;
    model_clear();
    #1;
    checks++;
    if (rbusy !== 2'b00 || rdata !== 64'h0 || issue_ready !== 1'b1) begin
      errors++;
      $display("FAIL async_reset got rbusy=%b rdata=%h ready=%b want 00/0/1",
               rbusy, rdata, issue_ready);
    end
    step();
    rst_n = 1'b1;
    raddr = {5'd9, 5'd7};
    #1;
    checks++;
    if (rbusy !== 2'b00 || rdata !== 64'h0) begin
      errors++;
      $display("FAIL post_reset got rbusy=%b rdata=%h want 00/0", rbusy, rdata);
    end
  endtask

  task automatic test_random();
    int a0, a1, rd;
    for (int n = 0; n < 400; n++) begin
      // Narrow address range half the time so bypass and busy collisions are common.
      if ($urandom_range(0, 1) == 1) begin
        a0 = $urandom_range(0, 7); a1 = $urandom_range(0, 7);
        waddr = 5'($urandom_range(0, 7)); rd = $urandom_range(0, 7);
      end else begin
        a0 = $urandom_range(0, 31); a1 = $urandom_range(0, 31);
        waddr = 5'($urandom_range(0, 31)); rd = $urandom_range(0, 31);
      end
      raddr = {5'(a1), 5'(a0)};
      we = ($urandom_range(0, 2) != 0);
      wdata = $urandom;
      issue_rd = 5'(rd);
      issue_valid = ($urandom_range(0, 1) == 1) && exp_ready(rd);
      #1;
      checks++;
      if (rdata[31:0] !== exp_rd(a0) || rdata[63:32] !== exp_rd(a1)) begin
        errors++;
        $display("FAIL rand_rdata n=%0d ra=%0d/%0d got %h want %h_%h",
                 n, a0, a1, rdata, exp_rd(a1), exp_rd(a0));
      end
      checks++;
      if (rbusy !== {exp_rbusy(a1), exp_rbusy(a0)}) begin
        errors++;
        $display("FAIL rand_rbusy n=%0d got %b want %b%b", n, rbusy, exp_rbusy(a1), exp_rbusy(a0));
      end
      checks++;
      if (issue_ready !== exp_ready(rd)) begin
        errors++;
        $display("FAIL rand_ready n=%0d rd=%0d got %b want %b", n, rd, issue_ready, exp_ready(rd));
      end
      step();
    end
    idle_inputs();
  endtask

  initial begin
    raddr = '0;
    test_reset();
    test_zero_reg();
    test_bypass();
    test_scoreboard();
    test_same_cycle_reissue();
    test_issue_zero();
    test_async_reset();
    test_random();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout got no finish want finish");
    $fatal(1, "timeout");
  end
endmodule
